// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and ready-handshaked instruction fetch stage for the single-cycle MIPS datapath
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] JrTarget,
  input  logic        ExStall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        InstrValid,
  output logic        AddrErr,
  output logic [31:0] RetireCount
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t      state;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  assign PC_plus_4  = PC + 32'd4;
  assign branch_off = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
  // jumps take priority; Branch only matters for the sequential/branch encoding
  assign next_pc = (PCSrc == 2'b01) ? {PC_plus_4[31:28], Instruction[25:0], 2'b00} :
                   (PCSrc == 2'b10) ? {JrTarget[31:2], 2'b00} :
                   (PCSrc == 2'b00 && Branch && Zero) ? PC_plus_4 + branch_off :
                   PC_plus_4;
  // request follows the state register, so an async reset drops it at once
  assign imem_req  = (state == FETCH);
  assign imem_addr = PC;
  assign OpCode    = Instruction[31:26];
  assign Funct     = Instruction[5:0];
  // fetch/execute sequencer: latch on ready, retire and advance PC when execute finishes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      Instruction <= NOP_WORD;
      InstrValid  <= 1'b0;
      AddrErr     <= 1'b0;
      RetireCount <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: if (imem_ready) begin
          Instruction <= imem_rdata;
          InstrValid  <= 1'b1;
          state       <= EXEC;
        end
        EXEC: if (!ExStall) begin
          PC          <= next_pc;
          RetireCount <= RetireCount + 32'd1;
          Instruction <= NOP_WORD;
          InstrValid  <= 1'b0;
          state       <= FETCH;
          if (PCSrc == 2'b10 && |JrTarget[1:0]) AddrErr <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
